// File: rtl/rr_req_agent.sv
// Requester-side companion to the round-robin arbiter: per-client token counters drive
// the request vector, arbiter grants retire tokens, and wait statistics are tracked.
module rr_req_agent #(
    parameter  int REQCNT     = 16,
    parameter  int PEND_W     = 3,
    parameter  int WAIT_W     = 16,
    parameter  int STARVE_LIM = 32,
    localparam int IDX_W      = $clog2(REQCNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REQCNT-1:0] push_i,
    output logic [REQCNT-1:0] push_rdy_o,
    output logic [REQCNT-1:0] req_o,
    output logic              req_val_o,
    input  logic [IDX_W-1:0]  req_num_i,
    input  logic              req_num_val_i,
    output logic [REQCNT-1:0] gnt_o,
    output logic              gnt_val_o,
    output logic [WAIT_W-1:0] max_wait_o,
    output logic [REQCNT-1:0] starve_o,
    output logic              spur_o,
    input  logic              clr_stat_i
);

    localparam int                LEAVES     = 1 << $clog2(REQCNT);
    localparam logic [PEND_W-1:0] PEND_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
    localparam logic [WAIT_W-1:0] STARVE_VAL = WAIT_W'(STARVE_LIM);

    logic [REQCNT-1:0] req;
    logic [REQCNT-1:0] grant_hit;
    logic [WAIT_W-1:0] wait_pad [LEAVES];
    logic [WAIT_W-1:0] tree_max;
    logic              spurious;

    logic [REQCNT-1:0] gnt_reg;
    logic              gnt_val_reg;
    logic [WAIT_W-1:0] max_wait_reg;
    logic              spur_reg;

    genvar gi;
    generate
        for (gi = 0; gi < REQCNT; gi++) begin : g_client
            logic [PEND_W-1:0] pend_reg;
            logic [PEND_W-1:0] pend_next;
            logic [WAIT_W-1:0] wait_reg;
            logic [WAIT_W-1:0] wait_next;
            logic              starve_reg;

            assign req[gi]        = (pend_reg != '0);
            assign push_rdy_o[gi] = (pend_reg != PEND_MAX);
            // An out-of-range index never matches any client, so it falls out as spurious.
            assign grant_hit[gi]  = req_num_val_i && (req_num_i == IDX_W'(gi)) && req[gi];
            assign wait_pad[gi]   = wait_reg;
            assign starve_o[gi]   = starve_reg;

            always_comb begin
                pend_next = pend_reg + PEND_W'(push_i[gi] && push_rdy_o[gi])
                                     - PEND_W'(grant_hit[gi]);
            end

            always_comb begin
                wait_next = wait_reg;
                if (!req[gi] || grant_hit[gi]) begin
                    wait_next = '0;
                end else if (wait_reg != WAIT_MAX) begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    pend_reg   <= '0;
                    wait_reg   <= '0;
                    starve_reg <= 1'b0;
                end else begin
                    pend_reg <= pend_next;
                    wait_reg <= wait_next;
                    if (clr_stat_i) begin
                        starve_reg <= 1'b0;
                    end else if (wait_reg == STARVE_VAL) begin
                        starve_reg <= 1'b1;
                    end
                end
            end
        end

        for (gi = REQCNT; gi < LEAVES; gi++) begin : g_pad
            assign wait_pad[gi] = '0;
        end
    endgenerate

    // Pairwise comparator tree over the padded leaf set; the result lands in lvl[0].
    always_comb begin
        logic [WAIT_W-1:0] lvl [LEAVES];
        for (int k = 0; k < LEAVES; k++) begin
            lvl[k] = wait_pad[k];
        end
        for (int s = 1; s < LEAVES; s = s * 2) begin
            for (int k = 0; k + s < LEAVES; k += 2 * s) begin
                if (lvl[k + s] > lvl[k]) begin
                    lvl[k] = lvl[k + s];
                end
            end
        end
        tree_max = lvl[0];
    end

    assign spurious = req_num_val_i && (grant_hit == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_reg      <= '0;
            gnt_val_reg  <= 1'b0;
            max_wait_reg <= '0;
            spur_reg     <= 1'b0;
        end else begin
            gnt_reg     <= grant_hit;
            gnt_val_reg <= |grant_hit;
            if (clr_stat_i) begin
                max_wait_reg <= '0;
                spur_reg     <= 1'b0;
            end else begin
                if (tree_max > max_wait_reg) begin
                    max_wait_reg <= tree_max;
                end
                if (spurious) begin
                    spur_reg <= 1'b1;
                end
            end
        end
    end

    assign req_o      = req;
    assign req_val_o  = |req;
    assign gnt_o      = gnt_reg;
    assign gnt_val_o  = gnt_val_reg;
    assign max_wait_o = max_wait_reg;
    assign spur_o     = spur_reg;

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed plus random stimulus for rr_req_agent, checked against a token/wait model
// expressed as plain integer bookkeeping per client.
module tb_rr_req_agent;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] push;
    logic [15:0] push_rdy;
    logic [15:0] req;
    logic        req_val;
    logic [3:0]  num;
    logic        num_val;
    logic [15:0] gnt;
    logic        gnt_val;
    logic [15:0] max_wait;
    logic [15:0] starve;
    logic        spur;
    logic        clr;

    int errors = 0;
    int checks = 0;

    int          pend_m [16];
    int          wait_m [16];
    logic [15:0] gnt_m;
    int          max_m;
    logic [15:0] starve_m;
    logic        spur_m;

    always #5 clk = ~clk;

    rr_req_agent dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .push_i       (push),
        .push_rdy_o   (push_rdy),
        .req_o        (req),
        .req_val_o    (req_val),
        .req_num_i    (num),
        .req_num_val_i(num_val),
        .gnt_o        (gnt),
        .gnt_val_o    (gnt_val),
        .max_wait_o   (max_wait),
        .starve_o     (starve),
        .spur_o       (spur),
        .clr_stat_i   (clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            pend_m[i] = 0;
            wait_m[i] = 0;
        end
        gnt_m    = '0;
        max_m    = 0;
        starve_m = '0;
        spur_m   = 1'b0;
    endtask

    // One clock edge worth of rules, all evaluated on the pre-edge state.
    task automatic model_edge(input logic [15:0] p, input logic gv, input logic [3:0] gidx,
                              input logic c);
        int   np [16];
        int   nw [16];
        int   mx;
        bit   valid;
        logic [15:0] ns;
        valid = gv && (pend_m[gidx] > 0);
        mx    = max_m;
        ns    = starve_m;
        for (int i = 0; i < 16; i++) begin
            bit granted;
            bit accepted;
            granted  = valid && (int'(gidx) == i);
            accepted = p[i] && (pend_m[i] < 7);
            np[i] = pend_m[i] + (accepted ? 1 : 0) - (granted ? 1 : 0);
            if (pend_m[i] == 0 || granted) nw[i] = 0;
            else nw[i] = (wait_m[i] >= 65535) ? 65535 : wait_m[i] + 1;
            if (wait_m[i] > mx) mx = wait_m[i];
            if (wait_m[i] == 32) ns[i] = 1'b1;
        end
        gnt_m = '0;
        if (valid) gnt_m[gidx] = 1'b1;
        if (gv && !valid) spur_m = 1'b1;
        max_m    = mx;
        starve_m = ns;
        if (c) begin
            max_m    = 0;
            starve_m = '0;
            spur_m   = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            pend_m[i] = np[i];
            wait_m[i] = nw[i];
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] req_e;
        logic [15:0] rdy_e;
        for (int i = 0; i < 16; i++) begin
            req_e[i] = (pend_m[i] != 0);
            rdy_e[i] = (pend_m[i] < 7);
        end
        chk({tag, ".req"}, 32'(req), 32'(req_e));
        chk({tag, ".req_val"}, 32'(req_val), 32'(|req_e));
        chk({tag, ".push_rdy"}, 32'(push_rdy), 32'(rdy_e));
        chk({tag, ".gnt"}, 32'(gnt), 32'(gnt_m));
        chk({tag, ".gnt_val"}, 32'(gnt_val), 32'(|gnt_m));
        chk({tag, ".max_wait"}, 32'(max_wait), 32'(max_m));
        chk({tag, ".starve"}, 32'(starve), 32'(starve_m));
        chk({tag, ".spur"}, 32'(spur), 32'(spur_m));
    endtask

    // Called one time unit after a rising edge: drive, cross the next edge, check.
    task automatic step(input string tag, input logic [15:0] p, input logic gv,
                        input logic [3:0] gidx, input logic c);
        push    = p;
        num_val = gv;
        num     = gidx;
        clr     = c;
        model_edge(p, gv, gidx, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int ptr;
        int cnt;
        logic [3:0] idx;

        rst_n   = 1'b0;
        push    = '0;
        num     = '0;
        num_val = 1'b0;
        clr     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single token round trip on client 0
        step("t1_push", 16'h0001, 1'b0, 4'd0, 1'b0);
        chk("t1.req_direct", 32'(req), 32'h0001);
        chk("t1.req_val_direct", 32'(req_val), 32'd1);
        step("t1_gnt", 16'h0000, 1'b1, 4'd0, 1'b0);
        chk("t1.gnt_direct", 32'(gnt), 32'h0001);
        chk("t1.req_drop", 32'(req), 32'h0000);
        step("t1_idle", 16'h0000, 1'b0, 4'd0, 1'b0);
        chk("t1.gnt_single_cycle", 32'(gnt), 32'h0000);

        // Fill client 3 to the limit, one extra push must be dropped
        for (int n = 0; n < 8; n++) step("t2_fill", 16'h0008, 1'b0, 4'd0, 1'b0);
        chk("t2.rdy_low", 32'(push_rdy[3]), 32'd0);
        cnt = 0;
        for (int n = 0; n < 7; n++) begin
            step("t2_drain", 16'h0000, 1'b1, 4'd3, 1'b0);
            if (gnt_val) cnt++;
        end
        chk("t2.grant_count", 32'(cnt), 32'd7);
        chk("t2.empty", 32'(req[3]), 32'd0);
        chk("t2.no_spur", 32'(spur), 32'd0);

        // Clients 8..15 loaded, served round-robin
        for (int n = 0; n < 7; n++) step("t3_load", 16'hFF00, 1'b0, 4'd0, 1'b0);
        ptr = 15;
        for (int n = 0; n < 56; n++) begin
            for (int k = 1; k <= 16; k++) begin
                if (pend_m[(ptr + k) % 16] > 0) begin
                    ptr = (ptr + k) % 16;
                    break;
                end
            end
            step("t3_rr", 16'h0000, 1'b1, 4'(ptr), (n == 8));
            chk("t3.rr_order", 32'(gnt), 32'(1) << (8 + n % 8));
        end
        chk("t3.max_wait", 32'(max_wait), 32'd7);
        chk("t3.no_starve", 32'(starve), 32'd0);

        // Starvation on client 5
        step("t4_push", 16'h0020, 1'b0, 4'd0, 1'b1);
        for (int n = 0; n < 41; n++) step("t4_hold", 16'h0000, 1'b0, 4'd0, 1'b0);
        chk("t4.starve5", 32'(starve), 32'h0020);
        chk("t4.max_wait", 32'(max_wait), 32'd40);
        step("t4_clr", 16'h0000, 1'b0, 4'd0, 1'b1);
        chk("t4.clr_starve", 32'(starve), 32'd0);
        chk("t4.clr_max", 32'(max_wait), 32'd0);
        step("t4_drain", 16'h0000, 1'b1, 4'd5, 1'b0);

        // Spurious grant, then push and grant together on client 4
        step("t5_spur", 16'h0000, 1'b1, 4'd2, 1'b0);
        chk("t5.spur_set", 32'(spur), 32'd1);
        chk("t5.no_gnt", 32'(gnt), 32'd0);
        step("t5_clr", 16'h0000, 1'b0, 4'd0, 1'b1);
        step("t5_push4", 16'h0010, 1'b0, 4'd0, 1'b0);
        step("t5_both", 16'h0010, 1'b1, 4'd4, 1'b0);
        chk("t5.req4_held", 32'(req[4]), 32'd1);
        step("t5_drain", 16'h0000, 1'b1, 4'd4, 1'b0);
        chk("t5.req4_gone", 32'(req[4]), 32'd0);

        // Asynchronous reset mid-stream
        for (int n = 0; n < 3; n++) step("t6_load", 16'h0F0F, 1'b0, 4'd0, 1'b0);
        push    = '0;
        num_val = 1'b1;
        num     = 4'd3;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6.rdy_all", 32'(push_rdy), 32'hFFFF);
        @(posedge clk);
        #1;
        check_all("t6_hold");
        rst_n = 1'b1;
        step("t6_post", 16'h0000, 1'b1, 4'd3, 1'b0);
        chk("t6.spur_post", 32'(spur), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idx = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (pend_m[(int'(idx) + k) % 16] > 0) begin
                        idx = 4'((int'(idx) + k) % 16);
                        break;
                    end
                end
            end
            step("rand", 16'($urandom) & 16'($urandom), 1'($urandom_range(0, 1)), idx,
                 ($urandom_range(0, 40) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
